four_bit_adder_2x2: RTL and testbench
=====================================

Name: four_bit_adder_2x2

Overview:
- 4-bit binary adder with carry-in and carry-out, built as two cascaded 2-bit adder groups.
- The low group adds bits [1:0] and ripples its carry into the high group, which adds bits [3:2].
- Sum, carry-out and signed-overflow are registered, with a simple valid flag.
- Used as an arithmetic leaf block and as the structural comparison point against the four-by-one full-adder chain.

Parameters:
- None. Width is fixed at 4 bits, split as 2 groups of 2 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- a  input  4  operand A, unsigned (also treated as two's-complement for ovf).
- b  input  4  operand B.
- cin  input  1  carry-in to bit 0.
- in_valid  input  1  qualifies a, b and cin for capture this cycle.
- s  output  4  registered sum.
- cout  output  1  registered carry-out of bit 3.
- ovf  output  1  registered signed overflow.
- out_valid  output  1  high for exactly the cycle after each accepted input.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. The ports are named clk and rst.
- Reset: at a rising edge with rst=1, all outputs clear: s=0, cout=0, ovf=0, out_valid=0. rst takes priority over in_valid on the same edge.
- Combinational datapath, low group: {c1, sl[1:0]} = a[1:0] + b[1:0] + cin.
- Combinational datapath, high group: {c4, sh[1:0]} = a[3:2] + b[3:2] + c1.
- Each group is a ripple of two full adders: sum = x^y^ci; co = (x&y)|(ci&(x^y)).
- Arithmetic: the full result equals the 5-bit value {c4, sh, sl} = a + b + cin. No truncation beyond the 4-bit sum; the carry always appears on cout.
- Overflow: ovf = c3 ^ c4, where c3 is the carry into bit 3. Equivalently, ovf=1 when a[3]==b[3] and s[3]!=a[3].
- Capture: at a rising edge with rst=0 and in_valid=1, register s<=sum, cout<=c4, ovf<=c3^c4, and out_valid<=1.
- Hold: at a rising edge with rst=0 and in_valid=0, s, cout and ovf hold their previous values, and out_valid<=0.
- Latency: exactly 1 cycle from input to output. Throughput is one add per cycle, with back-to-back in_valid supported.
- No backpressure and no stall input; the block is always ready.
- Boundary cases:
  - 15+15+1 = 31: s=4'hF, cout=1.
  - 0+0+0: s=0, cout=0, ovf=0.
  - Wrap-around: s always equals the low 4 bits of the sum.
- Reset during a stream: an input presented in the same cycle as rst=1 is discarded. Capture resumes on the first edge after rst deasserts.
- X-free: with known inputs and after reset, no output is ever X.

Decomposition:
- Shared package: constant ADDER_W=4, constant GROUP_W=2, and a typedef nibble_t = logic [3:0]. No enums are needed.
- Sub-module two_bit_adder: inputs x[1:0], y[1:0], ci; outputs sum[1:0], co, c_msb_in (carry into its bit 1).
  - c_msb_in of the high instance provides c3 for overflow.
- The top level instantiates two two_bit_adder instances plus the output register stage.
- two_bit_adder itself may contain two full-adder instances.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1, a=5, b=6 -> s=0, cout=0, ovf=0, out_valid=0 throughout. Deassert rst -> the next edge captures s=11, cout=0.
- Incremental sequence, one per cycle with in_valid=1: (a=0,b=0,cin=0) -> s=0; (1,0,0) -> s=1; (1,1,0) -> s=2; (1,1,1) -> s=3. cout=0 and ovf=0 for all, each result appearing 1 cycle after its input.
- Inter-group carry and wrap-around:
  - a=3, b=1, cin=0 -> s=4, cout=0 (carry c1 crosses into the high group).
  - a=15, b=1, cin=0 -> s=0, cout=1.
  - a=15, b=15, cin=1 -> s=15, cout=1.
- Signed overflow:
  - a=7, b=1 -> s=8, ovf=1, cout=0.
  - a=8, b=8 -> s=0, ovf=1, cout=1.
  - a=15, b=1 -> ovf=0.
- Hold and valid: capture a=9, b=4 (s=13), then drop in_valid and change a and b for 3 cycles -> s stays 13 and out_valid=1 for one cycle only.
- Exhaustive: all 512 combinations of (a,b,cin) back-to-back -> {cout,s} == a+b+cin and ovf matches the reference formula, checked one cycle later.

Source files
------------

// File: rtl/four_bit_adder_2x2_pkg.sv
// Shared widths, the nibble type and full-adder helper equations for the
// 4-bit adder built from two cascaded 2-bit groups.
package four_bit_adder_2x2_pkg;

  localparam int ADDER_W = 4;
  localparam int GROUP_W = 2;

  typedef logic [ADDER_W-1:0] nibble_t;

  // Single-bit full adder, sum output.
  function automatic logic fa_sum(input logic x, input logic y, input logic ci);
    return x ^ y ^ ci;
  endfunction

  // Single-bit full adder, carry output.
  function automatic logic fa_carry(input logic x, input logic y, input logic ci);
    return (x & y) | (ci & (x ^ y));
  endfunction

endpackage : four_bit_adder_2x2_pkg

// File: rtl/four_bit_adder_2x2_if.sv
// Operand/result bundle for the 4-bit adder. The master drives operands and
// in_valid; the slave (the adder) returns the registered result.
interface four_bit_adder_2x2_if;
  import four_bit_adder_2x2_pkg::*;

  nibble_t a;
  nibble_t b;
  logic    cin;
  logic    in_valid;
  nibble_t s;
  logic    cout;
  logic    ovf;
  logic    out_valid;

  modport master (
    output a, b, cin, in_valid,
    input  s, cout, ovf, out_valid
  );

  modport slave (
    input  a, b, cin, in_valid,
    output s, cout, ovf, out_valid
  );

endinterface : four_bit_adder_2x2_if

// File: rtl/four_bit_adder_2x2_two_bit_adder.sv
// Two-bit ripple group made of two full adders. c_msb_in exposes the carry
// into the group's upper bit so the parent can derive signed overflow.
module two_bit_adder
  import four_bit_adder_2x2_pkg::*;
(
  input  logic [GROUP_W-1:0] x,
  input  logic [GROUP_W-1:0] y,
  input  logic               ci,
  output logic [GROUP_W-1:0] sum,
  output logic               co,
  output logic               c_msb_in
);

  // Ripple the carry from bit 0 into bit 1.
  always_comb begin
    sum[0]   = fa_sum(x[0], y[0], ci);
    c_msb_in = fa_carry(x[0], y[0], ci);
    sum[1]   = fa_sum(x[1], y[1], c_msb_in);
    co       = fa_carry(x[1], y[1], c_msb_in);
  end

endmodule : two_bit_adder

// File: rtl/four_bit_adder_2x2.sv
// 4-bit adder with carry-in/out and signed overflow, built from a low and a
// high 2-bit group, followed by a single output register stage with valid.
module four_bit_adder_2x2
  import four_bit_adder_2x2_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  four_bit_adder_2x2_if.slave  bus
);

  logic [GROUP_W-1:0] sum_lo;
  logic [GROUP_W-1:0] sum_hi;
  logic               c1;
  logic               c3;
  logic               c4;
  logic               c_lo_msb_unused;

  nibble_t s_q,    s_d;
  logic    cout_q, cout_d;
  logic    ovf_q,  ovf_d;
  logic    vld_q,  vld_d;

  two_bit_adder u_lo (
    .x        (bus.a[1:0]),
    .y        (bus.b[1:0]),
    .ci       (bus.cin),
    .sum      (sum_lo),
    .co       (c1),
    .c_msb_in (c_lo_msb_unused)
  );

  two_bit_adder u_hi (
    .x        (bus.a[3:2]),
    .y        (bus.b[3:2]),
    .ci       (c1),
    .sum      (sum_hi),
    .co       (c4),
    .c_msb_in (c3)
  );

  // Next-state: capture on in_valid, otherwise hold the result and drop valid.
  always_comb begin
    s_d    = s_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    vld_d  = 1'b0;
    if (bus.in_valid) begin
      s_d    = {sum_hi, sum_lo};
      cout_d = c4;
      ovf_d  = c3 ^ c4;
      vld_d  = 1'b1;
    end
  end

  // Output register; reset wins over a same-edge capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      s_q    <= s_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      vld_q  <= vld_d;
    end
  end

  // Drive the result side of the bundle.
  always_comb begin
    bus.s         = s_q;
    bus.cout      = cout_q;
    bus.ovf       = ovf_q;
    bus.out_valid = vld_q;
  end

endmodule : four_bit_adder_2x2

// File: tb/tb_four_bit_adder_2x2.sv
// Scoreboard bench: the driver pushes the reference result for every accepted
// input; an independent monitor pops and compares when out_valid appears.
module tb_four_bit_adder_2x2;
  import four_bit_adder_2x2_pkg::*;

  typedef struct packed {
    logic [3:0] s;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  four_bit_adder_2x2_if bif();

  four_bit_adder_2x2 dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow.
  function automatic exp_t model(input int a, input int b, input int c);
    exp_t e;
    int   total, sa, sb, sr;
    total  = a + b + c;
    sa     = (a >= 8) ? a - 16 : a;
    sb     = (b >= 8) ? b - 16 : b;
    sr     = sa + sb + c;
    e.s    = 4'(total % 16);
    e.cout = (total >= 16);
    e.ovf  = (sr > 7) || (sr < -8);
    return e;
  endfunction

  // Drive one cycle of inputs at the falling edge; log expectation if accepted.
  task automatic drive(input int a, input int b, input int c, input logic v, input logic r);
    @(negedge clk);
    rst          = r;
    bif.a        = 4'(a);
    bif.b        = 4'(b);
    bif.cin      = c[0];
    bif.in_valid = v;
    if (v && !r) exp_q.push_back(model(a, b, c));
  endtask

  // Monitor: sample just after each rising edge.
  initial begin
    logic       rst_e;
    exp_t       e;
    logic [3:0] last_s    = '0;
    logic       last_cout = 1'b0;
    logic       last_ovf  = 1'b0;
    forever begin
      @(posedge clk);
      rst_e = rst;
      #1;
      if (rst_e) begin
        chk("rst_s",     int'(bif.s),         0);
        chk("rst_cout",  int'(bif.cout),      0);
        chk("rst_ovf",   int'(bif.ovf),       0);
        chk("rst_valid", int'(bif.out_valid), 0);
        last_s = '0; last_cout = 1'b0; last_ovf = 1'b0;
        exp_q.delete();
      end else if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_valid", int'(bif.out_valid), 1);
        chk("sum",       int'(bif.s),         int'(e.s));
        chk("cout",      int'(bif.cout),      int'(e.cout));
        chk("ovf",       int'(bif.ovf),       int'(e.ovf));
        last_s = e.s; last_cout = e.cout; last_ovf = e.ovf;
      end else begin
        chk("idle_valid", int'(bif.out_valid), 0);
        chk("hold_s",     int'(bif.s),         int'(last_s));
        chk("hold_cout",  int'(bif.cout),      int'(last_cout));
        chk("hold_ovf",   int'(bif.ovf),       int'(last_ovf));
      end
    end
  end

  initial begin
    bif.a = '0; bif.b = '0; bif.cin = 1'b0; bif.in_valid = 1'b0;

    // Reset held two cycles with a live input that must be discarded.
    drive(5, 6, 0, 1'b1, 1'b1);
    drive(5, 6, 0, 1'b1, 1'b1);
    drive(5, 6, 0, 1'b1, 1'b0);

    // Incremental sequence.
    drive(0, 0, 0, 1'b1, 1'b0);
    drive(1, 0, 0, 1'b1, 1'b0);
    drive(1, 1, 0, 1'b1, 1'b0);
    drive(1, 1, 1, 1'b1, 1'b0);

    // Inter-group carry, wrap-around, overflow corners.
    drive(3, 1, 0, 1'b1, 1'b0);
    drive(15, 1, 0, 1'b1, 1'b0);
    drive(15, 15, 1, 1'b1, 1'b0);
    drive(7, 1, 0, 1'b1, 1'b0);
    drive(8, 8, 0, 1'b1, 1'b0);
    drive(15, 1, 0, 1'b1, 1'b0);

    // Hold: capture 9+4 then change operands with in_valid low.
    drive(9, 4, 0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(2 + i, 7 - i, i % 2, 1'b0, 1'b0);
    @(negedge clk);
    chk("hold13_s",     int'(bif.s),         13);
    chk("hold13_valid", int'(bif.out_valid), 0);
    bif.in_valid = 1'b0;

    // Exhaustive back-to-back.
    for (int c = 0; c < 2; c++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          drive(a, b, c, 1'b1, 1'b0);

    // Randomized stream with gaps and an occasional mid-stream reset.
    for (int i = 0; i < 400; i++)
      drive(int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(1)),
            ($urandom_range(3) != 0), ($urandom_range(49) == 0));

    // Drain and confirm nothing was left unanswered.
    drive(0, 0, 0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_four_bit_adder_2x2
